effective_address_unit: RTL
===========================

// Module: effective_address_unit
// PURPOSE
//  Address-generation stage downstream of the X/Y index registers in the 65C02 core.
//  Collects operand bytes from the data bus and fetches zero-page pointers for indirect modes.
//  Adds the latched index and presents a 16-bit effective address to the bus/sequencer, with a page-cross flag.
//  Covers zp,X / zp,Y / abs,X / abs,Y / (zp,X) / (zp),Y / abs / zp.
// PARAMETERS
//  none (widths fixed by 65C02 architecture: 8-bit data, 16-bit address)
// PORTS
//  fclk        in   1   core clock; all state on rising edge
//  resb        in   1   reset, asynchronous, active-low
//  start       in   1   begin address generation; accepted only when busy=0
//  ea_mode     in   3   cpu65_pkg::ea_mode_t, sampled with start
//  index_x     in   8   X register value, sampled with start
//  index_y     in   8   Y register value (index_register_Y address_out), sampled with start
//  db_in       in   8   operand / pointer byte from data bus
//  db_valid    in   1   db_in holds the byte currently awaited
//  flush       in   1   synchronous abort (interrupt/branch)
//  ptr_addr    out  16  zero-page pointer fetch address {8'h00,ptr}
//  ptr_rd      out  1   pointer read request, high in PTR_LO/PTR_HI
//  ea_out      out  16  effective address; held until next accepted start
//  ea_valid    out  1   one-cycle strobe, ea_out is final
//  page_cross  out  1   carry out of low-byte add (abs,X/abs,Y/(zp),Y only); held with ea_out
//  busy        out  1   state != IDLE
//  dummy_rd    out  1   fix-up dummy read strobe (EAU_PAGE_PENALTY_EN only, else tied 0)
// BEHAVIOUR
//  Reset: state=IDLE; ea_out=0, ea_valid=0, page_cross=0, ptr_addr=0, ptr_rd=0, dummy_rd=0, busy=0.
//   Async reset mid-operation aborts immediately; no ea_valid.
//  FSM: IDLE, OP_LO, OP_HI, PTR_LO, PTR_HI, CALC, FIX, DONE.
//  IDLE:   start -> latch ea_mode, index_x, index_y -> OP_LO. start while busy ignored.
//  OP_LO:  wait db_valid; base_lo=db_in.
//          zp modes -> CALC; abs modes -> OP_HI; (zp,X)/(zp),Y -> PTR_LO.
//  OP_HI:  wait db_valid; base_hi=db_in -> CALC.
//  PTR_LO: ptr = (zp,X) ? (op+X) mod 256 : op.
//          ptr_addr={00,ptr}, ptr_rd=1; on db_valid base_lo=db_in -> PTR_HI.
//  PTR_HI: ptr_addr={00,(ptr+1) mod 256} (0xFF wraps to 0x00), ptr_rd=1.
//          On db_valid base_hi=db_in -> CALC.
//  CALC:   zp,X/zp,Y: ea={00,(base_lo+idx) mod 256}, page_cross=0.
//          abs,X/abs,Y/(zp),Y: ea={base_hi,base_lo}+idx mod 2^16, page_cross=carry(base_lo+idx).
//          abs/zp/(zp,X): ea=base, page_cross=0.
//          -> DONE (or FIX, see CONFIGURATION).
//  DONE:   ea_valid=1 exactly one cycle -> IDLE. start accepted again the following cycle.
//  Latency (db_valid always high): zp 3 cycles start->ea_valid; abs 4; indirect 5.
//  db_valid outside OP_LO/OP_HI/PTR_LO/PTR_HI ignored; db_valid low stalls, no timeout.
//  flush: any state -> IDLE next edge; no ea_valid; ea_out/page_cross keep previous values.
//   flush and start in the same cycle: flush wins, start dropped.
// CONFIGURATION
//  EAU_PAGE_PENALTY_EN defined: CALC with page_cross=1 -> FIX for one cycle.
//   FIX drives dummy_rd=1, ptr_addr={base_hi,sum_lo} (unfixed address), then -> DONE.
//   Adds +1 cycle latency on page cross.
//  Undefined: FIX unreachable; CALC always -> DONE; dummy_rd constant 0.
// STRUCTURE
//  cpu65_pkg: ea_mode_t {EA_ZPX,EA_ZPY,EA_ABSX,EA_ABSY,EA_INDX,EA_INDY,EA_ABS,EA_ZP},
//   eau_state_t, ZP_PAGE=8'h00.
//  Sub-module ea_adder: 16-bit base + 8-bit index, outputs sum, low-byte carry, zp-wrapped sum.
// TESTING
//  1 abs,Y: Y=10, bytes 34,12 -> ea_out=1244, page_cross=0, ea_valid 4 cycles after start.
//  2 abs,X: X=FF, bytes F0,12 -> ea_out=13EF, page_cross=1.
//    With EN: dummy_rd at 12EF, ea_valid at cycle 5.
//  3 zp,X: X=90, byte 80 -> ea_out=0010 (zp wrap), page_cross=0.
//  4 (zp),Y: op=FF, mem[00FF]=00, mem[0000]=20, Y=05 -> ptr_rd 00FF then 0000, ea_out=2005.
//  5 (zp,X): op=70, X=95, mem[05]=34, mem[06]=12 -> ptr_addr 0005/0006, ea_out=1234.
//  6 flush in OP_HI -> IDLE, no ea_valid.
//    resb low during PTR_HI -> all outputs 0 immediately; restart behaves as test 1.

Source files
------------

// File: rtl/cpu65_pkg.sv
// rtl/cpu65_pkg.sv - shared 65C02 core types for the effective address unit
package cpu65_pkg;

    typedef enum logic [2:0] {
        EA_ZPX, EA_ZPY, EA_ABSX, EA_ABSY, EA_INDX, EA_INDY, EA_ABS, EA_ZP
    } ea_mode_t;

    typedef enum logic [2:0] {
        ST_IDLE, ST_OP_LO, ST_OP_HI, ST_PTR_LO, ST_PTR_HI, ST_CALC, ST_FIX, ST_DONE
    } eau_state_t;

    localparam logic [7:0] ZP_PAGE = 8'h00;

    function automatic logic is_zp_mode(input ea_mode_t m);
        return (m == EA_ZPX) || (m == EA_ZPY) || (m == EA_ZP);
    endfunction

    function automatic logic is_ind_mode(input ea_mode_t m);
        return (m == EA_INDX) || (m == EA_INDY);
    endfunction

    function automatic logic uses_index_y(input ea_mode_t m);
        return (m == EA_ZPY) || (m == EA_ABSY) || (m == EA_INDY);
    endfunction

    function automatic logic reports_page_cross(input ea_mode_t m);
        return (m == EA_ABSX) || (m == EA_ABSY) || (m == EA_INDY);
    endfunction

endpackage

// File: rtl/ea_adder.sv
// rtl/ea_adder.sv - 16-bit base plus 8-bit index with low-byte carry and zero-page wrap
module ea_adder
    import cpu65_pkg::*;
(
    input  logic [15:0] i_base,
    input  logic [7:0]  i_index,
    output logic [15:0] o_sum,
    output logic        o_carry_lo,
    output logic [15:0] o_zp_sum
);

    logic [7:0] w_sum_lo;

    assign {o_carry_lo, w_sum_lo} = {1'b0, i_base[7:0]} + {1'b0, i_index};
    assign o_sum    = {i_base[15:8] + {7'b0, o_carry_lo}, w_sum_lo};
    assign o_zp_sum = {ZP_PAGE, w_sum_lo};

endmodule

// File: rtl/effective_address_unit.sv
// rtl/effective_address_unit.sv - 65C02 effective address generation FSM
// Optional: EAU_PAGE_PENALTY_EN adds a FIX cycle with a dummy read on page cross.
module effective_address_unit
    import cpu65_pkg::*;
(
    input  logic        fclk,
    input  logic        resb,
    input  logic        start,
    input  ea_mode_t    ea_mode,
    input  logic [7:0]  index_x,
    input  logic [7:0]  index_y,
    input  logic [7:0]  db_in,
    input  logic        db_valid,
    input  logic        flush,
    output logic [15:0] ptr_addr,
    output logic        ptr_rd,
    output logic [15:0] ea_out,
    output logic        ea_valid,
    output logic        page_cross,
    output logic        busy,
    output logic        dummy_rd
);

    eau_state_t  r_state;
    ea_mode_t    r_mode;
    logic [7:0]  r_idx_x;
    logic [7:0]  r_idx_y;
    logic [7:0]  r_base_lo;
    logic [7:0]  r_base_hi;
    logic [7:0]  r_ptr;
    logic [15:0] r_ptr_addr;
    logic        r_ptr_rd;
    logic [15:0] r_ea;
    logic        r_ea_valid;
    logic        r_page_cross;

    logic [7:0]  w_index;
    logic [7:0]  w_ptr_next;
    logic [15:0] w_sum;
    logic        w_carry;
    logic [15:0] w_zp_sum;

    assign w_index    = uses_index_y(r_mode) ? r_idx_y : r_idx_x;
    // (zp,X) pre-indexes the pointer itself; the add wraps inside page zero
    assign w_ptr_next = (r_mode == EA_INDX) ? (db_in + r_idx_x) : db_in;

    ea_adder u_adder (
        .i_base     ({r_base_hi, r_base_lo}),
        .i_index    (w_index),
        .o_sum      (w_sum),
        .o_carry_lo (w_carry),
        .o_zp_sum   (w_zp_sum)
    );

`ifdef EAU_PAGE_PENALTY_EN
    logic r_dummy_rd;
    assign dummy_rd = r_dummy_rd;
`else
    assign dummy_rd = 1'b0;
`endif

    always_ff @(posedge fclk or negedge resb) begin
        if (!resb) begin
            r_state      <= ST_IDLE;
            r_mode       <= EA_ZPX;
            r_idx_x      <= 8'h00;
            r_idx_y      <= 8'h00;
            r_base_lo    <= 8'h00;
            r_base_hi    <= 8'h00;
            r_ptr        <= 8'h00;
            r_ptr_addr   <= 16'h0000;
            r_ptr_rd     <= 1'b0;
            r_ea         <= 16'h0000;
            r_ea_valid   <= 1'b0;
            r_page_cross <= 1'b0;
`ifdef EAU_PAGE_PENALTY_EN
            r_dummy_rd   <= 1'b0;
`endif
        end else if (flush) begin
            r_state    <= ST_IDLE;
            r_ptr_rd   <= 1'b0;
            r_ea_valid <= 1'b0;
`ifdef EAU_PAGE_PENALTY_EN
            r_dummy_rd <= 1'b0;
`endif
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_mode  <= ea_mode;
                        r_idx_x <= index_x;
                        r_idx_y <= index_y;
                        r_state <= ST_OP_LO;
                    end
                end
                ST_OP_LO: begin
                    if (db_valid) begin
                        r_base_lo <= db_in;
                        if (is_zp_mode(r_mode)) begin
                            r_base_hi <= ZP_PAGE;
                            r_state   <= ST_CALC;
                        end else if (is_ind_mode(r_mode)) begin
                            r_ptr      <= w_ptr_next;
                            r_ptr_addr <= {ZP_PAGE, w_ptr_next};
                            r_ptr_rd   <= 1'b1;
                            r_state    <= ST_PTR_LO;
                        end else begin
                            r_state <= ST_OP_HI;
                        end
                    end
                end
                ST_OP_HI: begin
                    if (db_valid) begin
                        r_base_hi <= db_in;
                        r_state   <= ST_CALC;
                    end
                end
                ST_PTR_LO: begin
                    if (db_valid) begin
                        r_base_lo  <= db_in;
                        r_ptr_addr <= {ZP_PAGE, r_ptr + 8'd1};
                        r_state    <= ST_PTR_HI;
                    end
                end
                ST_PTR_HI: begin
                    if (db_valid) begin
                        r_base_hi <= db_in;
                        r_ptr_rd  <= 1'b0;
                        r_state   <= ST_CALC;
                    end
                end
                ST_CALC: begin
                    if (r_mode == EA_ZPX || r_mode == EA_ZPY) begin
                        r_ea         <= w_zp_sum;
                        r_page_cross <= 1'b0;
                    end else if (reports_page_cross(r_mode)) begin
                        r_ea         <= w_sum;
                        r_page_cross <= w_carry;
                    end else begin
                        r_ea         <= {r_base_hi, r_base_lo};
                        r_page_cross <= 1'b0;
                    end
`ifdef EAU_PAGE_PENALTY_EN
                    if (reports_page_cross(r_mode) && w_carry) begin
                        r_ptr_addr <= {r_base_hi, w_sum[7:0]};
                        r_dummy_rd <= 1'b1;
                        r_state    <= ST_FIX;
                    end else begin
                        r_ea_valid <= 1'b1;
                        r_state    <= ST_DONE;
                    end
`else
                    r_ea_valid <= 1'b1;
                    r_state    <= ST_DONE;
`endif
                end
                ST_FIX: begin
`ifdef EAU_PAGE_PENALTY_EN
                    r_dummy_rd <= 1'b0;
`endif
                    r_ea_valid <= 1'b1;
                    r_state    <= ST_DONE;
                end
                ST_DONE: begin
                    r_ea_valid <= 1'b0;
                    r_state    <= ST_IDLE;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign ptr_addr   = r_ptr_addr;
    assign ptr_rd     = r_ptr_rd;
    assign ea_out     = r_ea;
    assign ea_valid   = r_ea_valid;
    assign page_cross = r_page_cross;
    assign busy       = (r_state != ST_IDLE);

endmodule
